snake_ctrl: RTL and testbench
=============================

# snake_ctrl

Game-sequencing controller for the VGA snake game. It owns the game state machine, the movement tick, direction latching, collision evaluation, apple placement, size and score. It drives the snake-position datapath through a step/step_done handshake, and exposes apple position, size and game_over to the renderer. All step requests are aligned to vertical blanking so the snake never moves mid-frame.

## Interface
Parameters:
- TICK_DIV, 1777777: the movement tick fires once every TICK_DIV+1 clocks.
- DEATH_TICKS, 8: number of ticks spent in the death flash.
- SIZE_INCREASE, 1: segments added per apple.
- MAX_SIZE, 31: saturation value for size.

Ports:
- VGA_clk  in  1  25 MHz pixel clock; the only clock.
- reset  in  1  synchronous, active-high.
- up, left, down, right  in  1 each  direction buttons, active-low.
- start  in  1  active-high start request.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking.
- step_done  in  1  one-cycle pulse from the datapath: the move has completed.
- head_x, head_y  in  7 each  new head cell; valid only with step_done.
- body_hit  in  1  new head overlaps a body segment; valid only with step_done.
- step  out  1  one-cycle move request to the datapath.
- step_dir  out  2  direction for the move: 00 up, 01 left, 10 down, 11 right.
- clear  out  1  one-cycle pulse: datapath places head at (40,30) and parks the other segments.
- size  out  5  current snake length.
- apple_x, apple_y  out  7 each  current apple cell.
- score  out  8  apples eaten, saturating.
- game_over  out  1  high in IDLE and DEATH.
- death_flash  out  1  red-screen flash enable.

## Operation
- States: IDLE, CLEAR, WAIT_TICK, WAIT_FRAME, STEP, WAIT_DONE, EVAL, RELOCATE, DEATH.
- IDLE: waits for start=1, then goes to CLEAR.
- CLEAR: asserts clear for one cycle. Sets size=1, score=0, committed direction=11 (right), apple=(40,10), clears tick_pending. Goes to WAIT_TICK.
- WAIT_TICK: when tick_pending=1, goes to WAIT_FRAME.
- WAIT_FRAME: on frame_start, goes to STEP.
- STEP: asserts step for one cycle, with step_dir = pending direction. The pending direction becomes the committed direction; tick_pending is cleared. Goes to WAIT_DONE.
- WAIT_DONE: on step_done, captures head_x, head_y and body_hit, then goes to EVAL. step_done in any other state is ignored.
- EVAL: evaluates with priority wall > body > apple.
  - Wall: head_x is 0 or 79, or head_y is 0 or 59. Goes to DEATH.
  - Body: body_hit=1. Goes to DEATH.
  - Apple: head equals (apple_x, apple_y). Sets size = min(size+SIZE_INCREASE, MAX_SIZE), score = min(score+1, 255), then goes to RELOCATE.
  - Otherwise goes to WAIT_TICK.
- RELOCATE: each cycle takes candidate x = lfsr[6:0], y = {1'b0, lfsr[13:8]}.
  - Accept if 1≤x≤78, 1�≤y≤58, and (x,y) ≠ captured head. On accept, load apple and go to WAIT_TICK.
  - Otherwise retry next cycle.
- DEATH: death_flash toggles on every tick, starting from 1 on entry. After DEATH_TICKS ticks it goes to IDLE with death_flash=0.
- Direction latch, evaluated every cycle in every state:
  - Valid only when exactly one button is low (one-hot-low pattern).
  - A direction opposite to the committed direction is rejected.
  - An accepted press overwrites the pending direction; the last valid press before STEP wins.
  - Invalid patterns (none pressed, or multiple pressed) leave the pending direction unchanged.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle, seed 16'hACE1 on reset, never zero.
- Tick: a counter runs 0..TICK_DIV in all states; tick=1 when count==TICK_DIV, and the count wraps to 0. A tick sets tick_pending (sticky); only STEP and CLEAR clear it.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: game_over=1, step=0, clear=0, death_flash=0, size=1, score=0, apple=(40,10), step_dir=11.
  - Internals: pending direction=11, tick count=0, tick_pending=0, lfsr=16'hACE1.
- Reset mid-operation (including WAIT_DONE) aborts to IDLE the next cycle; no further step is issued.
- All outputs are registered.
- step rises one cycle after the frame_start that is sampled in WAIT_FRAME.
- size, score and apple update in the cycle after EVAL.
- frame_start arriving in the same cycle that tick_pending first moves WAIT_TICK→WAIT_FRAME is not used; the controller waits for the next frame_start.
- A tick arriving during EVAL or RELOCATE is retained via tick_pending.
- step_done with no maximum latency; the controller waits indefinitely in WAIT_DONE.
- game_over is high in IDLE and DEATH and low in all other states, registered with the state.

## Test plan
- Reset, then start=1 → clear pulses exactly 1 cycle, game_over goes 0, size=1, score=0; with TICK_DIV=15 the first step follows the first frame_start after tick 1, with step_dir=11.
- Committed direction right; press left only → rejected, next step_dir=11. Press up → next step_dir=00. up+down held together → no change.
- step_done with head=(40,10), body_hit=0 → score=1, size=2; apple moves to a cell in [1..78]×[1..58] not equal to (40,10), within the LFSR-accepted cycles.
- step_done with head=(79,30) and body_hit=1 → DEATH (wall has priority), game_over=1; death_flash toggles for 8 ticks, then IDLE.
- score at 255 and size at 31 with a further apple hit → both stay saturated; no wrap.
- Assert reset during WAIT_DONE, then pulse step_done → stays IDLE with no step or clear; all outputs at reset values.

Source files
------------

// File: rtl/snake_ctrl.sv
// Game sequencer for the VGA snake: state machine, movement tick, direction latch,
// collision evaluation, apple placement, size and score.
module snake_ctrl #(
  parameter int unsigned TICK_DIV      = 1777777,
  parameter int unsigned DEATH_TICKS   = 8,
  parameter int unsigned SIZE_INCREASE = 1,
  parameter int unsigned MAX_SIZE      = 31
) (
  input  logic       VGA_clk,
  input  logic       reset,
  input  logic       up,
  input  logic       left,
  input  logic       down,
  input  logic       right,
  input  logic       start,
  input  logic       frame_start,
  input  logic       step_done,
  input  logic [6:0] head_x,
  input  logic [6:0] head_y,
  input  logic       body_hit,
  output logic       step,
  output logic [1:0] step_dir,
  output logic       clear,
  output logic [4:0] size,
  output logic [6:0] apple_x,
  output logic [6:0] apple_y,
  output logic [7:0] score,
  output logic       game_over,
  output logic       death_flash
);

  localparam int unsigned CNT_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam int unsigned DTH_W = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;
  localparam logic [1:0]  DIR_UP    = 2'b00;
  localparam logic [1:0]  DIR_LEFT  = 2'b01;
  localparam logic [1:0]  DIR_DOWN  = 2'b10;
  localparam logic [1:0]  DIR_RIGHT = 2'b11;
  localparam logic [6:0]  APPLE_X0  = 7'd40;
  localparam logic [6:0]  APPLE_Y0  = 7'd10;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [3:0] {
    IDLE, CLEAR, WAIT_TICK, WAIT_FRAME, STEP, WAIT_DONE, EVAL, RELOCATE, DEATH
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   tick_cnt;
  logic               tick_pending;
  logic [DTH_W-1:0]   death_cnt;
  logic [15:0]        lfsr;
  logic [1:0]         pend_dir;
  logic [1:0]         commit_dir;
  logic [6:0]         cap_x;
  logic [6:0]         cap_y;
  logic               cap_hit;

  logic               tick;
  logic [3:0]         pressed;
  logic               press_vld;
  logic [1:0]         press_dir;
  logic [1:0]         ref_dir;
  logic               press_ok;
  logic [6:0]         cand_x;
  logic [6:0]         cand_y;
  logic               cand_ok;
  logic               at_wall;
  logic               at_apple;
  logic [31:0]        size_sum;
  logic [4:0]         size_inc;
  logic [7:0]         score_inc;

  // Direction decode; reversal is judged against the direction about to be committed.
  always_comb begin
    press_vld = 1'b0;
    press_dir = DIR_RIGHT;
    pressed   = ~{right, down, left, up};
    case (pressed)
      4'b0001: begin press_vld = 1'b1; press_dir = DIR_UP;    end
      4'b0010: begin press_vld = 1'b1; press_dir = DIR_LEFT;  end
      4'b0100: begin press_vld = 1'b1; press_dir = DIR_DOWN;  end
      4'b1000: begin press_vld = 1'b1; press_dir = DIR_RIGHT; end
      default: ;
    endcase
    ref_dir  = (state == WAIT_FRAME && frame_start) ? pend_dir : commit_dir;
    press_ok = press_vld && (press_dir != (ref_dir ^ 2'b10));
  end

  always_comb begin
    tick      = (tick_cnt == CNT_W'(TICK_DIV));
    cand_x    = lfsr[6:0];
    cand_y    = {1'b0, lfsr[13:8]};
    cand_ok   = (cand_x >= 7'd1) && (cand_x <= 7'd78) &&
                (cand_y >= 7'd1) && (cand_y <= 7'd58) &&
                !((cand_x == cap_x) && (cand_y == cap_y));
    at_wall   = (cap_x == 7'd0) || (cap_x == 7'd79) || (cap_y == 7'd0) || (cap_y == 7'd59);
    at_apple  = (cap_x == apple_x) && (cap_y == apple_y);
    size_sum  = 32'(size) + SIZE_INCREASE;
    size_inc  = (size_sum > MAX_SIZE) ? 5'(MAX_SIZE) : 5'(size_sum);
    score_inc = (score == 8'hFF) ? score : score + 8'd1;
  end

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      tick_pending <= 1'b0;
      death_cnt    <= '0;
      lfsr         <= LFSR_SEED;
      pend_dir     <= DIR_RIGHT;
      commit_dir   <= DIR_RIGHT;
      cap_x        <= '0;
      cap_y        <= '0;
      cap_hit      <= 1'b0;
      step         <= 1'b0;
      step_dir     <= DIR_RIGHT;
      clear        <= 1'b0;
      size         <= 5'd1;
      apple_x      <= APPLE_X0;
      apple_y      <= APPLE_Y0;
      score        <= '0;
      game_over    <= 1'b1;
      death_flash  <= 1'b0;
    end else begin
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
      if (state == STEP || state == CLEAR) tick_pending <= 1'b0;
      else if (tick)                       tick_pending <= 1'b1;
      step  <= 1'b0;
      clear <= 1'b0;
      if (press_ok) pend_dir <= press_dir;

      case (state)
        IDLE: if (start) begin
          state       <= CLEAR;
          clear       <= 1'b1;
          game_over   <= 1'b0;
          death_flash <= 1'b0;
          size        <= 5'd1;
          score       <= '0;
          apple_x     <= APPLE_X0;
          apple_y     <= APPLE_Y0;
          commit_dir  <= DIR_RIGHT;
          pend_dir    <= DIR_RIGHT;
        end
        CLEAR:     state <= WAIT_TICK;
        WAIT_TICK: if (tick_pending) state <= WAIT_FRAME;
        WAIT_FRAME: if (frame_start) begin
          state      <= STEP;
          step       <= 1'b1;
          step_dir   <= pend_dir;
          commit_dir <= pend_dir;
        end
        STEP:      state <= WAIT_DONE;
        WAIT_DONE: if (step_done) begin
          cap_x   <= head_x;
          cap_y   <= head_y;
          cap_hit <= body_hit;
          state   <= EVAL;
        end
        EVAL: begin
          if (at_wall || cap_hit) begin
            state       <= DEATH;
            game_over   <= 1'b1;
            death_flash <= 1'b1;
            death_cnt   <= '0;
          end else if (at_apple) begin
            size  <= size_inc;
            score <= score_inc;
            state <= RELOCATE;
          end else begin
            state <= WAIT_TICK;
          end
        end
        RELOCATE: if (cand_ok) begin
          apple_x <= cand_x;
          apple_y <= cand_y;
          state   <= WAIT_TICK;
        end
        // Flash toggles per tick; the final tick returns to IDLE with the flash off.
        DEATH: if (tick) begin
          if (death_cnt == DTH_W'(DEATH_TICKS - 1)) begin
            state       <= IDLE;
            death_flash <= 1'b0;
          end else begin
            death_flash <= ~death_flash;
            death_cnt   <= death_cnt + DTH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_ctrl.sv
// Directed bench for snake_ctrl with a short tick period (TICK_DIV=15).
module tb_snake_ctrl;

  logic       VGA_clk = 1'b0;
  logic       reset = 1'b1;
  logic       up = 1'b1, left = 1'b1, down = 1'b1, right = 1'b1;
  logic       start = 1'b0, frame_start = 1'b0, step_done = 1'b0, body_hit = 1'b0;
  logic [6:0] head_x = '0, head_y = '0;
  logic       step, clear, game_over, death_flash;
  logic [1:0] step_dir;
  logic [4:0] size;
  logic [6:0] apple_x, apple_y;
  logic [7:0] score;

  int tests = 0;
  int fails = 0;

  snake_ctrl #(.TICK_DIV(15), .DEATH_TICKS(8), .SIZE_INCREASE(1), .MAX_SIZE(31)) dut (
    .VGA_clk(VGA_clk), .reset(reset), .up(up), .left(left), .down(down), .right(right),
    .start(start), .frame_start(frame_start), .step_done(step_done),
    .head_x(head_x), .head_y(head_y), .body_hit(body_hit),
    .step(step), .step_dir(step_dir), .clear(clear), .size(size),
    .apple_x(apple_x), .apple_y(apple_y), .score(score),
    .game_over(game_over), .death_flash(death_flash)
  );

  always #20 VGA_clk = ~VGA_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_game_over"}, 32'(game_over), 32'd1);
    check({tag, "_step"}, 32'(step), 32'd0);
    check({tag, "_clear"}, 32'(clear), 32'd0);
    check({tag, "_flash"}, 32'(death_flash), 32'd0);
    check({tag, "_size"}, 32'(size), 32'd1);
    check({tag, "_score"}, 32'(score), 32'd0);
    check({tag, "_apple_x"}, 32'(apple_x), 32'd40);
    check({tag, "_apple_y"}, 32'(apple_y), 32'd10);
    check({tag, "_step_dir"}, 32'(step_dir), 32'd3);
  endtask

  // Hold frame_start until step appears; returns one cycle later, in WAIT_DONE.
  task automatic run_step(input string tag, input logic [1:0] exp_dir);
    logic       seen = 1'b0;
    logic [1:0] dir  = '0;
    frame_start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge VGA_clk);
      if (step) begin
        seen = 1'b1;
        dir  = step_dir;
        break;
      end
    end
    frame_start = 1'b0;
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_dir"}, 32'(dir), 32'(exp_dir));
    @(negedge VGA_clk);
    check({tag, "_pulse"}, 32'(step), 32'd0);
  endtask

  // Deliver step_done; returns after EVAL has been applied.
  task automatic finish_step(input logic [6:0] x, input logic [6:0] y, input logic hit);
    head_x = x; head_y = y; body_hit = hit; step_done = 1'b1;
    @(negedge VGA_clk);
    step_done = 1'b0; body_hit = 1'b0;
    @(negedge VGA_clk);
  endtask

  task automatic wait_relocate(input string tag, input logic [6:0] ox, input logic [6:0] oy);
    logic moved = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge VGA_clk);
      if (apple_x != ox || apple_y != oy) begin
        moved = 1'b1;
        break;
      end
    end
    check({tag, "_moved"}, 32'(moved), 32'd1);
  endtask

  task automatic press(input logic [3:0] btn_n);
    {right, down, left, up} = btn_n;
    @(negedge VGA_clk);
    {right, down, left, up} = 4'b1111;
  endtask

  initial begin
    logic any_step, any_clear, prev_flash;
    int   rises, falls;
    logic [6:0] ax, ay;

    repeat (3) @(negedge VGA_clk);
    check_reset_vals("rst");
    reset = 1'b0;

    // Start: one-cycle clear and game-start values
    start = 1'b1;
    @(negedge VGA_clk);
    check("clear_hi", 32'(clear), 32'd1);
    check("start_game_over", 32'(game_over), 32'd0);
    check("start_size", 32'(size), 32'd1);
    check("start_score", 32'(score), 32'd0);
    start = 1'b0;
    @(negedge VGA_clk);
    check("clear_one_cycle", 32'(clear), 32'd0);

    // frame_start before the first tick must not move the snake
    frame_start = 1'b1;
    @(negedge VGA_clk);
    frame_start = 1'b0;
    any_step = 1'b0;
    repeat (24) begin
      @(negedge VGA_clk);
      any_step |= step;
    end
    check("no_step_before_tick", 32'(any_step), 32'd0);
    frame_start = 1'b1;
    @(negedge VGA_clk);
    frame_start = 1'b0;
    check("first_step_latency", 32'(step), 32'd1);
    check("first_step_dir", 32'(step_dir), 32'd3);
    @(negedge VGA_clk);
    check("first_step_pulse", 32'(step), 32'd0);
    finish_step(7'd41, 7'd30, 1'b0);
    check("plain_move_score", 32'(score), 32'd0);
    check("plain_move_over", 32'(game_over), 32'd0);

    // Direction latch: reversal rejected, up accepted, double press ignored
    press(4'b1101);
    run_step("rej_left", 2'b11);
    finish_step(7'd42, 7'd30, 1'b0);
    press(4'b1110);
    run_step("up", 2'b00);
    finish_step(7'd42, 7'd29, 1'b0);
    press(4'b1010);
    run_step("up_down", 2'b00);

    // Apple at (40,10)
    finish_step(7'd40, 7'd10, 1'b0);
    check("apple_score", 32'(score), 32'd1);
    check("apple_size", 32'(size), 32'd2);
    wait_relocate("reloc", 7'd40, 7'd10);
    check("reloc_x_range", 32'(apple_x >= 7'd1 && apple_x <= 7'd78), 32'd1);
    check("reloc_y_range", 32'(apple_y >= 7'd1 && apple_y <= 7'd58), 32'd1);

    // Wall plus body hit: death, 7 toggles over 8 ticks, then idle
    run_step("pre_death", 2'b00);
    finish_step(7'd79, 7'd30, 1'b1);
    check("death_over", 32'(game_over), 32'd1);
    check("death_flash_entry", 32'(death_flash), 32'd1);
    check("death_score_kept", 32'(score), 32'd1);
    rises = 0; falls = 0; prev_flash = death_flash;
    repeat (160) begin
      @(negedge VGA_clk);
      if (death_flash && !prev_flash) rises++;
      if (!death_flash && prev_flash) falls++;
      prev_flash = death_flash;
    end
    check("death_rises", 32'(rises), 32'd3);
    check("death_falls", 32'(falls), 32'd4);
    check("death_flash_end", 32'(death_flash), 32'd0);
    check("death_idle_over", 32'(game_over), 32'd1);

    // Restart and saturate size and score
    start = 1'b1;
    @(negedge VGA_clk);
    start = 1'b0;
    check("restart_clear", 32'(clear), 32'd1);
    check("restart_score", 32'(score), 32'd0);
    for (int k = 0; k < 256; k++) begin
      run_step("sat", 2'b11);
      ax = apple_x; ay = apple_y;
      finish_step(ax, ay, 1'b0);
      if (k == 29) check("size_reach_max", 32'(size), 32'd31);
      if (k == 30) check("size_hold_max", 32'(size), 32'd31);
      if (k == 254) check("score_reach_max", 32'(score), 32'd255);
      wait_relocate("sat_reloc", ax, ay);
    end
    check("score_saturated", 32'(score), 32'd255);
    check("size_saturated", 32'(size), 32'd31);
    check("sat_alive", 32'(game_over), 32'd0);

    // Reset while waiting for step_done
    run_step("pre_reset", 2'b11);
    reset = 1'b1;
    @(negedge VGA_clk);
    reset = 1'b0;
    head_x = 7'd40; head_y = 7'd10; step_done = 1'b1;
    @(negedge VGA_clk);
    step_done = 1'b0;
    frame_start = 1'b1;
    any_step = 1'b0; any_clear = 1'b0;
    repeat (40) begin
      @(negedge VGA_clk);
      any_step  |= step;
      any_clear |= clear;
    end
    frame_start = 1'b0;
    check("post_reset_no_step", 32'(any_step), 32'd0);
    check("post_reset_no_clear", 32'(any_clear), 32'd0);
    check_reset_vals("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
